// File: rtl/cndm_micro_irq_msi_if.sv
// MSI request channel between the interrupt message generator and the PCIe MSI block.
interface cndm_micro_irq_msi_if #(
    parameter int IRQ_W = 5
) ();
    logic             msi_req_valid;
    logic [IRQ_W-1:0] msi_req_index;
    logic             msi_req_ready;

    modport master (
        output msi_req_valid,
        output msi_req_index,
        input  msi_req_ready
    );

    modport slave (
        input  msi_req_valid,
        input  msi_req_index,
        output msi_req_ready
    );
endinterface

// File: rtl/cndm_micro_irq_msi.sv
// Interrupt message generator: edge-detects per-port interrupts into pending bits,
// round-robin arbitrates the unmasked ones and issues one MSI request at a time,
// with a programmable holdoff gap after every accepted message.
module cndm_micro_irq_msi #(
    parameter int PORTS     = 2,
    parameter int IRQ_W     = 5,
    parameter int IRQ_BASE  = 0,
    parameter int HOLDOFF_W = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [PORTS-1:0]     irq,
    input  logic [PORTS-1:0]     irq_mask,
    input  logic [HOLDOFF_W-1:0] holdoff,
    output logic [PORTS-1:0]     irq_pending,
    cndm_micro_irq_msi_if.master msi
);

    localparam int SEL_W = (PORTS > 1) ? $clog2(PORTS) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        HOLD = 2'd2
    } state_t;

    state_t               r_state;
    state_t               w_stateNext;
    logic [PORTS-1:0]     r_irqD;
    logic [PORTS-1:0]     r_pending;
    logic [PORTS-1:0]     w_event;
    logic [PORTS-1:0]     w_elig;
    logic [PORTS-1:0]     w_clear;
    logic [SEL_W-1:0]     r_ptr;
    logic [SEL_W-1:0]     r_sel;
    logic [SEL_W-1:0]     w_pick;
    logic                 w_found;
    logic                 w_accept;
    logic                 w_issue;
    logic                 w_holdLoad;
    logic [HOLDOFF_W-1:0] r_cnt;
    logic                 r_valid;
    logic [IRQ_W-1:0]     r_index;
    logic [IRQ_W-1:0]     w_index;

    assign w_event  = irq & ~r_irqD;
    assign w_elig   = r_pending & ~irq_mask;
    assign w_accept = (r_state == REQ) && msi.msi_req_ready;
    assign w_index  = IRQ_W'(IRQ_BASE + int'(w_pick));

    assign msi.msi_req_valid = r_valid;
    assign msi.msi_req_index = r_index;
    assign irq_pending       = r_pending;

    // Round-robin pick: first eligible source after the last served one, wrapping.
    always_comb begin
        w_found = 1'b0;
        w_pick  = '0;
        for (int k = 1; k <= PORTS; k++) begin
            if (!w_found && w_elig[(int'(r_ptr) + k) % PORTS]) begin
                w_found = 1'b1;
                w_pick  = SEL_W'((int'(r_ptr) + k) % PORTS);
            end
        end
    end

    // One-hot clear of the source being accepted this cycle.
    always_comb begin
        w_clear = '0;
        w_clear[r_sel] = w_accept;
    end

    // Next-state logic for the issue / wait-for-ready / holdoff sequence.
    always_comb begin
        w_stateNext = r_state;
        w_issue     = 1'b0;
        w_holdLoad  = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_found) begin
                    w_issue     = 1'b1;
                    w_stateNext = REQ;
                end
            end
            REQ: begin
                if (msi.msi_req_ready) begin
                    if (holdoff == '0) begin
                        w_stateNext = IDLE;
                    end else begin
                        w_holdLoad  = 1'b1;
                        w_stateNext = HOLD;
                    end
                end
            end
            HOLD: begin
                if (r_cnt <= HOLDOFF_W'(1)) begin
                    w_stateNext = IDLE;
                end
            end
            default: w_stateNext = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_stateNext;
        end
    end

    // Pending bits, arbitration pointer, request latch and holdoff counter; a new edge beats a same-cycle clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_irqD    <= '0;
            r_pending <= '0;
            r_ptr     <= SEL_W'(PORTS - 1);
            r_sel     <= '0;
            r_valid   <= 1'b0;
            r_index   <= '0;
            r_cnt     <= '0;
        end else begin
            r_irqD    <= irq;
            r_pending <= (r_pending & ~w_clear) | w_event;
            if (w_issue) begin
                r_sel   <= w_pick;
                r_index <= w_index;
                r_valid <= 1'b1;
            end else if (w_accept) begin
                r_ptr   <= r_sel;
                r_valid <= 1'b0;
            end
            if (w_holdLoad) begin
                r_cnt <= holdoff;
            end else if (r_state == HOLD) begin
                r_cnt <= r_cnt - HOLDOFF_W'(1);
            end
        end
    end

endmodule
